// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Avalon-MM round-robin arbiter.
package sdram_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a master index; a single master still needs one bit.
  function automatic int mid_width(input int num_masters);
    return (num_masters > 2) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/read_owner_fifo.sv
// Synchronous FIFO of master ids; remembers who owns each outstanding read.
module read_owner_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] din,
  input  logic            pop,
  output logic [ID_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop frees the slot in the same cycle, so push is allowed when full and popping.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller s1 port between several
// Avalon-MM masters, routing pipelined read data back to its issuer.
module sdram_avalon_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 32,
  parameter int BE_W        = 4,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic [BE_W-1:0]               s_byteenable_n,
  output logic                          s_chipselect,
  output logic [DATA_W-1:0]             s_writedata,
  output logic                          s_read_n,
  output logic                          s_write_n,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  input  logic                          s_waitrequest,
  output logic                          err_unexpected_rdv
);

  localparam int MID_W = mid_width(NUM_MASTERS);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } cmd_t;

  arb_state_t             state_q, state_d;
  logic [MID_W-1:0]       grant_q, grant_d;
  logic [MID_W-1:0]       rr_q, rr_d;
  logic                   err_q;
  logic [NUM_MASTERS-1:0] req;
  logic [MID_W-1:0]       pick;
  logic                   pick_vld;
  cmd_t                   cmd;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [MID_W-1:0]       fifo_dout;

  assign req                = m_read | m_write;
  assign err_unexpected_rdv = err_q;

  // First requester at or after rr_q, then wrap around to the lower indices.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_vld && req[i] && (MID_W'(i) >= rr_q)) begin
        pick_vld = 1'b1;
        pick     = MID_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!pick_vld && req[i]) begin
        pick_vld = 1'b1;
        pick     = MID_W'(i);
      end
    end
  end

  // Live command of the granted master; a write masks a simultaneous read.
  always_comb begin
    cmd = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == MID_W'(i)) begin
        cmd.addr  = m_address[i*ADDR_W +: ADDR_W];
        cmd.be    = m_byteenable[i*BE_W +: BE_W];
        cmd.wdata = m_writedata[i*DATA_W +: DATA_W];
        cmd.wr    = m_write[i];
        cmd.rd    = m_read[i] & ~m_write[i];
      end
    end
  end

  // Handshake: a command transfers on the cycle the slave sees chipselect with
  // read_n or write_n low and waitrequest low; only then is the granted
  // master's waitrequest released, and masters hold their command until then.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    fifo_push      = 1'b0;
    m_waitrequest  = '1;
    s_chipselect   = 1'b0;
    s_read_n       = 1'b1;
    s_write_n      = 1'b1;
    s_byteenable_n = '1;
    s_address      = '0;
    s_writedata    = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!cmd.rd && !cmd.wr) begin
          state_d = IDLE;
        end else if (cmd.wr || !fifo_full) begin
          s_chipselect   = 1'b1;
          s_address      = cmd.addr;
          s_byteenable_n = ~cmd.be;
          s_writedata    = cmd.wdata;
          s_write_n      = ~cmd.wr;
          s_read_n       = ~cmd.rd;
          if (!s_waitrequest) begin
            m_waitrequest = ~(NUM_MASTERS'(1) << grant_q);
            fifo_push     = cmd.rd;
            rr_d          = (grant_q == MID_W'(NUM_MASTERS-1)) ? '0 : grant_q + MID_W'(1);
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (s_readdatavalid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read data is steered to the oldest outstanding owner with zero latency.
  assign fifo_pop = s_readdatavalid & ~fifo_empty;

  always_comb begin
    m_readdatavalid = '0;
    m_readdata      = '0;
    if (fifo_pop) begin
      m_readdatavalid = NUM_MASTERS'(1) << fifo_dout;
      m_readdata      = s_readdata;
    end
  end

  read_owner_fifo #(
    .ID_W  (MID_W),
    .DEPTH (MAX_PENDING)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (grant_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed bench for sdram_avalon_arbiter with a per-cycle protocol/owner model.
module tb_sdram_avalon_arbiter;

  localparam int NM   = 2;
  localparam int MW   = 1;
  localparam int AW   = 25;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXP = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM*AW-1:0] m_address;
  logic [NM*BW-1:0] m_byteenable;
  logic [NM*DW-1:0] m_writedata;
  logic [NM-1:0]    m_read;
  logic [NM-1:0]    m_write;
  logic [NM-1:0]    m_waitrequest;
  logic [DW-1:0]    m_readdata;
  logic [NM-1:0]    m_readdatavalid;
  logic [AW-1:0]    s_address;
  logic [BW-1:0]    s_byteenable_n;
  logic             s_chipselect;
  logic [DW-1:0]    s_writedata;
  logic             s_read_n;
  logic             s_write_n;
  logic [DW-1:0]    s_readdata;
  logic             s_readdatavalid;
  logic             s_waitrequest;
  logic             err_unexpected_rdv;

  int            n_cmp;
  int            n_err;
  logic [NM-1:0] exp_q[$];
  int            acc_log[$];
  logic          model_err;

  sdram_avalon_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .BE_W        (BW),
    .MAX_PENDING (MAXP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .m_address          (m_address),
    .m_byteenable       (m_byteenable),
    .m_writedata        (m_writedata),
    .m_read             (m_read),
    .m_write            (m_write),
    .m_waitrequest      (m_waitrequest),
    .m_readdata         (m_readdata),
    .m_readdatavalid    (m_readdatavalid),
    .s_address          (s_address),
    .s_byteenable_n     (s_byteenable_n),
    .s_chipselect       (s_chipselect),
    .s_writedata        (s_writedata),
    .s_read_n           (s_read_n),
    .s_write_n          (s_write_n),
    .s_readdata         (s_readdata),
    .s_readdatavalid    (s_readdatavalid),
    .s_waitrequest      (s_waitrequest),
    .err_unexpected_rdv (err_unexpected_rdv)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted command must appear on s1 intact, and each
  // readdatavalid goes to the oldest still-unanswered reader.
  task automatic compare_cycle();
    int            n_acc;
    int            acc_m;
    logic          s_acc;
    logic          wr;
    logic [NM-1:0] exp_rdv;
    logic [BW-1:0] ben_exp;
    if (rst) begin
      exp_q.delete();
      model_err = 1'b0;
      return;
    end
    n_acc = 0;
    acc_m = 0;
    for (int i = 0; i < NM; i++) begin
      if (!m_waitrequest[i]) begin
        n_acc++;
        acc_m = i;
        check("wait_low_needs_request", m_read[i] | m_write[i], 1'b1);
      end
    end
    s_acc = s_chipselect && (!s_read_n || !s_write_n) && !s_waitrequest;
    check("accept_count", n_acc, s_acc ? 1 : 0);
    check("err_flag", err_unexpected_rdv, model_err);
    if (exp_q.size() >= MAXP) check("read_held_when_full", s_read_n, 1'b1);
    exp_rdv = '0;
    if (s_readdatavalid) begin
      if (exp_q.size() == 0) model_err = 1'b1;
      else exp_rdv = exp_q.pop_front();
    end
    check("rdv_strobe", m_readdatavalid, exp_rdv);
    if (exp_rdv != '0) check("readdata", m_readdata, s_readdata);
    if (n_acc == 1 && s_acc) begin
      wr      = m_write[acc_m];
      ben_exp = ~m_byteenable[acc_m*BW +: BW];
      acc_log.push_back(acc_m);
      check("s_address", s_address, m_address[acc_m*AW +: AW]);
      check("s_byteenable_n", s_byteenable_n, ben_exp);
      check("s_write_n", s_write_n, !wr);
      check("s_read_n", s_read_n, wr);
      if (wr) check("s_writedata", s_writedata, m_writedata[acc_m*DW +: DW]);
      else exp_q.push_back(NM'(1) << acc_m);
    end
  endtask

  // Driver tasks
  task automatic drive_cmd(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
    m_read[m]                = rd;
    m_write[m]               = wr;
    m_address[m*AW +: AW]    = a;
    m_writedata[m*DW +: DW]  = d;
    m_byteenable[m*BW +: BW] = be;
  endtask

  task automatic idle_master(input int m);
    drive_cmd(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_accept(input int m, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (!m_waitrequest[m]) done = 1'b1;
    end
    if (!done) check("handshake_timeout", m_waitrequest[m], 1'b0);
  endtask

  task automatic issue(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be,
                       output int cyc, output logic wn, output logic [BW-1:0] ben);
    drive_cmd(m, rd, wr, a, d, be);
    wait_accept(m, cyc);
    wn  = s_write_n;
    ben = s_byteenable_n;
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [DW-1:0] data, output logic [NM-1:0] rdv, output logic [DW-1:0] rdata);
    s_readdatavalid = 1'b1;
    s_readdata      = data;
    @(negedge clk);
    rdv   = m_readdatavalid;
    rdata = m_readdata;
    @(posedge clk);
    #1;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
  endtask

  initial begin
    int            cyc, cyc0, cyc1, max_cyc, held;
    logic          wn, wn0, wn1;
    logic [BW-1:0] ben, ben0, ben1;
    logic [NM-1:0] r1, r2, r3;
    logic [DW-1:0] d1, d2, d3;
    int            exp_order[8];

    n_cmp = 0;
    n_err = 0;
    model_err = 1'b0;
    rst = 1'b1;
    m_address = '0;
    m_byteenable = '0;
    m_writedata = '0;
    m_read = '0;
    m_write = '0;
    s_readdata = '0;
    s_readdatavalid = 1'b0;
    s_waitrequest = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_m_waitrequest", m_waitrequest, 2'b11);
    check("rst_m_readdatavalid", m_readdatavalid, 2'b00);
    check("rst_m_readdata", m_readdata, 32'h0);
    check("rst_s_read_n", s_read_n, 1'b1);
    check("rst_s_write_n", s_write_n, 1'b1);
    check("rst_s_chipselect", s_chipselect, 1'b0);
    check("rst_s_byteenable_n", s_byteenable_n, 4'hF);
    check("rst_s_address", s_address, 25'h0);
    check("rst_s_writedata", s_writedata, 32'h0);
    check("rst_err", err_unexpected_rdv, 1'b0);

    // Single write from master 0: accepted on the second cycle
    @(posedge clk);
    #1;
    issue(0, 1'b0, 1'b1, 25'h10, 32'h0003A5A5, 4'b0011, cyc, wn, ben);
    idle_master(0);
    check("t1_latency", cyc, 2);
    check("t1_write_n", wn, 1'b0);
    check("t1_byteenable_n", ben, 4'b1100);

    // Two continuous writers alternate, starting with master 1 (rr now 1)
    acc_log.delete();
    max_cyc = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          issue(0, 1'b0, 1'b1, 25'h100 + 25'(k), 32'hA0000000 + 32'(k), 4'hF, cyc0, wn0, ben0);
          if (cyc0 > max_cyc) max_cyc = cyc0;
        end
        idle_master(0);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          issue(1, 1'b0, 1'b1, 25'h200 + 25'(k), 32'hB0000000 + 32'(k), 4'b0101, cyc1, wn1, ben1);
          if (cyc1 > max_cyc) max_cyc = cyc1;
        end
        idle_master(1);
      end
    join
    exp_order = '{1, 0, 1, 0, 1, 0, 1, 0};
    check("t2_accept_total", acc_log.size(), 8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++) check("t2_grant_order", acc_log[k], exp_order[k]);
    check("t2_max_wait_le_4", (max_cyc <= 4), 1'b1);

    // Master 1 read, data returned three cycles after acceptance
    issue(1, 1'b1, 1'b0, 25'h20, '0, 4'hF, cyc, wn, ben);
    idle_master(1);
    repeat (2) @(posedge clk);
    #1;
    ret(32'hDEADBEEF, r1, d1);
    check("t3_rdv", r1, 2'b10);
    check("t3_readdata", d1, 32'hDEADBEEF);

    // Eight outstanding reads fill the owner FIFO; the ninth is held
    for (int k = 0; k < 8; k++) issue(0, 1'b1, 1'b0, 25'h300 + 25'(k), '0, 4'hF, cyc, wn, ben);
    drive_cmd(0, 1'b1, 1'b0, 25'h308, '0, 4'hF);
    held = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!m_waitrequest[0] || !s_read_n) held++;
    end
    check("t4_ninth_not_forwarded", held, 0);
    check("t4_ninth_wait", m_waitrequest[0], 1'b1);
    @(posedge clk);
    #1;
    ret(32'h00001000, r1, d1);
    check("t4_first_return", r1, 2'b01);
    wait_accept(0, cyc);
    check("t4_forward_after_pop", cyc, 1);
    @(posedge clk);
    #1;
    idle_master(0);
    for (int k = 0; k < 8; k++) begin
      ret(32'h00001001 + 32'(k), r1, d1);
      check("t4_drain_rdv", r1, 2'b01);
    end

    // Interleaved m0, m1, m0 reads with returns overlapping acceptances
    issue(0, 1'b1, 1'b0, 25'h400, '0, 4'hF, cyc, wn, ben);
    idle_master(0);
    fork
      begin
        issue(1, 1'b1, 1'b0, 25'h401, '0, 4'hF, cyc, wn, ben);
        idle_master(1);
      end
      begin
        @(posedge clk);
        #1;
        ret(32'h11111111, r1, d1);
      end
    join
    fork
      begin
        issue(0, 1'b1, 1'b0, 25'h402, '0, 4'hF, cyc, wn, ben);
        idle_master(0);
      end
      begin
        @(posedge clk);
        #1;
        ret(32'h22222222, r2, d2);
      end
    join
    ret(32'h33333333, r3, d3);
    check("t5_strobe_1", r1, 2'b01);
    check("t5_strobe_2", r2, 2'b10);
    check("t5_strobe_3", r3, 2'b01);
    check("t5_data_2", d2, 32'h22222222);

    // Reset with a read in flight; the late return is flagged and dropped
    issue(1, 1'b1, 1'b0, 25'h500, '0, 4'hF, cyc, wn, ben);
    idle_master(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ret(32'h55555555, r1, d1);
    check("t6_rdv_dropped", r1, 2'b00);
    @(negedge clk);
    check("t6_err_set", err_unexpected_rdv, 1'b1);

    // Master 0 withdraws while stalled: rr stays at 0
    @(posedge clk);
    #1;
    s_waitrequest = 1'b1;
    drive_cmd(0, 1'b0, 1'b1, 25'h600, 32'h66666666, 4'hF);
    repeat (3) @(negedge clk);
    check("t7_stall_wait", m_waitrequest[0], 1'b1);
    @(posedge clk);
    #1;
    idle_master(0);
    @(posedge clk);
    #1;
    s_waitrequest = 1'b0;
    acc_log.delete();
    fork
      begin
        issue(0, 1'b0, 1'b1, 25'h700, 32'h77770000, 4'hF, cyc0, wn0, ben0);
        idle_master(0);
      end
      begin
        issue(1, 1'b0, 1'b1, 25'h701, 32'h77770001, 4'hF, cyc1, wn1, ben1);
        idle_master(1);
      end
    join
    check("t7_accept_total", acc_log.size(), 2);
    if (acc_log.size() > 0) check("t7_first_grant", acc_log[0], 0);

    // Read and write together: write wins, nothing queued for readback
    issue(0, 1'b1, 1'b1, 25'h800, 32'hCAFE0001, 4'b1010, cyc, wn, ben);
    idle_master(0);
    check("t8_write_wins", wn, 1'b0);
    check("t8_byteenable_n", ben, 4'b0101);
    ret(32'h88888888, r1, d1);
    check("t8_no_owner", r1, 2'b00);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
